// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions for the M-stage exception unit.
// Holds the CP0 register numbers, the ExcCode values, the SR/Cause bit
// positions, the default handler and PRId values, the EXL state encoding and
// a helper that computes the restart PC recorded in EPC.
package cp0_exception_unit_pkg;

    // CP0 register numbers (rd field of MTC0/MFC0)
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // SR / Cause field positions
    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_BD_BIT  = 31;

    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
    localparam logic [31:0] PRID_VALUE_DEF   = 32'h1926_0817;

    typedef enum logic {
        EXL_NORMAL  = 1'b0,
        EXL_HANDLER = 1'b1
    } exl_state_e;

    // Restart PC: a delay-slot instruction must resume at its branch.
    function automatic logic [31:0] epc_restart(input logic [31:0] pc, input logic bd);
        logic [29:0] word;
        word = bd ? (pc[31:2] - 30'd1) : pc[31:2];
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_exception_unit_if.sv
// M-stage pipeline <-> CP0 bus.
// master: the pipeline (drives PC/decode/MTC0 data, receives read data,
//         flush request, handler PC and ERET target).
// slave : the CP0 exception unit.
interface cp0_exception_unit_if;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic        cp0_we;
    logic        is_eret;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        exc_take;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    modport master (
        output pc_m, bd_m, exc_code_m, cp0_we, is_eret, cp0_addr, cp0_wdata,
        input  cp0_rdata, exc_take, handler_pc, epc_out
    );

    modport slave (
        input  pc_m, bd_m, exc_code_m, cp0_we, is_eret, cp0_addr, cp0_wdata,
        output cp0_rdata, exc_take, handler_pc, epc_out
    );
endinterface

// File: rtl/cp0_int_sync.sv
// Two-flop synchroniser for the asynchronous, level-sensitive interrupt lines.
// Ports: clk, reset_n (async active-low), din (async lines), dout (synchronised).
module cp0_int_sync #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sync1_reg;
    logic [W-1:0] sync2_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
        end
    end

    assign dout = sync2_reg;

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 register file (SR, Cause, EPC, PRId) and exception/interrupt sequencer
// for the M stage of the 5-stage MIPS core.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   hw_int        external interrupt lines (async, level), land in Cause.IP
//   bus           slave side of cp0_exception_unit_if: M-stage PC/BD/ExcCode,
//                 MTC0/MFC0/ERET controls in; read data, exc_take flush,
//                 handler_pc and epc_out (ERET target) out.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
    parameter logic [31:0] PRID_VALUE   = PRID_VALUE_DEF,
    parameter int          HW_INT_W     = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [HW_INT_W-1:0] hw_int,
    cp0_exception_unit_if.slave bus
);

    logic [HW_INT_W-1:0] hw_int_sync;
    logic [5:0]          cause_ip;

    cp0_int_sync #(.W(HW_INT_W)) u_int_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (hw_int),
        .dout    (hw_int_sync)
    );

    // Cause.IP is the synchroniser output itself: two edges from pin to IP.
    assign cause_ip = 6'(hw_int_sync);

    exl_state_e  state_reg, state_next;
    logic [5:0]  sr_im_reg;
    logic        sr_ie_reg;
    logic        cause_bd_reg;
    logic [4:0]  cause_exc_reg;
    logic [31:0] epc_reg;

    logic        sr_exl;
    logic        int_req;
    logic        exc_req;
    logic        exc_take;
    logic        sr_wr;
    logic        epc_wr;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign sr_exl   = (state_reg == EXL_HANDLER);
    assign int_req  = (|(cause_ip & sr_im_reg)) & sr_ie_reg & ~sr_exl;
    assign exc_req  = (bus.exc_code_m != EXC_INT) & ~sr_exl;
    assign exc_take = int_req | exc_req;

    // A taken exception squashes the MTC0 sitting in M.
    assign sr_wr  = bus.cp0_we & ~exc_take & (bus.cp0_addr == CP0_SR);
    assign epc_wr = bus.cp0_we & ~exc_take & (bus.cp0_addr == CP0_EPC);

    // EXL state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= EXL_NORMAL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (exc_take) begin
            state_next = EXL_HANDLER;
        end else if (bus.is_eret) begin
            state_next = EXL_NORMAL;
        end else if (sr_wr) begin
            state_next = bus.cp0_wdata[SR_EXL_BIT] ? EXL_HANDLER : EXL_NORMAL;
        end
    end

    // SR.IM/IE, Cause.BD/ExcCode and EPC
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_im_reg     <= '0;
            sr_ie_reg     <= 1'b0;
            cause_bd_reg  <= 1'b0;
            cause_exc_reg <= '0;
            epc_reg       <= '0;
        end else begin
            if (sr_wr) begin
                sr_im_reg <= bus.cp0_wdata[SR_IM_LSB +: 6];
                sr_ie_reg <= bus.cp0_wdata[SR_IE_BIT];
            end
            if (exc_take) begin
                cause_exc_reg <= int_req ? EXC_INT : bus.exc_code_m;
                cause_bd_reg  <= bus.bd_m;
                epc_reg       <= epc_restart(bus.pc_m, bus.bd_m);
            end else if (epc_wr) begin
                epc_reg <= {bus.cp0_wdata[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        sr_word                      = '0;
        sr_word[SR_IM_LSB +: 6]      = sr_im_reg;
        sr_word[SR_EXL_BIT]          = sr_exl;
        sr_word[SR_IE_BIT]           = sr_ie_reg;
        cause_word                   = '0;
        cause_word[CAUSE_BD_BIT]     = cause_bd_reg;
        cause_word[CAUSE_IP_LSB +: 6] = cause_ip;
        cause_word[CAUSE_EXC_LSB +: 5] = cause_exc_reg;
    end

    // MFC0 sees pre-edge register contents (no write bypass).
    always_comb begin
        case (bus.cp0_addr)
            CP0_SR:    bus.cp0_rdata = sr_word;
            CP0_CAUSE: bus.cp0_rdata = cause_word;
            CP0_EPC:   bus.cp0_rdata = epc_reg;
            CP0_PRID:  bus.cp0_rdata = PRID_VALUE;
            default:   bus.cp0_rdata = '0;
        endcase
    end

    // ERET target forwards an MTC0 EPC issued in the same cycle.
    assign bus.epc_out    = (bus.cp0_we && bus.cp0_addr == CP0_EPC) ?
                            {bus.cp0_wdata[31:2], 2'b00} : epc_reg;
    assign bus.exc_take   = exc_take;
    assign bus.handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_exception_unit.sv
module tb_cp0_exception_unit;
    import cp0_exception_unit_pkg::*;

    localparam int SEL_RDATA = 0;
    localparam int SEL_TAKE  = 1;
    localparam int SEL_EPC   = 2;
    localparam int SEL_HPC   = 3;

    logic       clk;
    logic       reset_n;
    logic [5:0] hw_int;

    cp0_exception_unit_if bus ();

    cp0_exception_unit #(
        .HANDLER_ADDR (32'h0000_4180),
        .PRID_VALUE   (32'h1926_0817),
        .HW_INT_W     (6)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hw_int  (hw_int),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_val(input string name, input int sel, input logic [31:0] v);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = v;
        sb.push_back(c);
    endtask

    task automatic idle();
        bus.pc_m       = 32'h0;
        bus.bd_m       = 1'b0;
        bus.exc_code_m = 5'd0;
        bus.cp0_we     = 1'b0;
        bus.is_eret    = 1'b0;
        bus.cp0_addr   = 5'd0;
        bus.cp0_wdata  = 32'h0;
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [4:0] addr, input string name, input logic [31:0] v);
        bus.cp0_addr = addr;
        expect_val(name, SEL_RDATA, v);
    endtask

    // Monitor: outputs are compared on the falling edge against queued expectations.
    initial begin : monitor
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                c = sb.pop_front();
                case (c.sel)
                    SEL_RDATA: act = bus.cp0_rdata;
                    SEL_TAKE:  act = {31'b0, bus.exc_take};
                    SEL_EPC:   act = bus.epc_out;
                    default:   act = bus.handler_pc;
                endcase
                n_checks++;
                if (act === c.exp) begin
                    n_pass++;
                    $display("check %-14s got %08h ok", c.name, act);
                end else begin
                    $display("FAIL %s: got %08h, expected %08h", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset_n = 1'b1;
        hw_int  = 6'b0;
        idle();

        // 1. Reset asserted mid-cycle, held across three rising edges
        #2;
        reset_n = 1'b0;
        rd(CP0_SR, "rst_sr", 32'h0);
        expect_val("rst_take", SEL_TAKE, 32'h0);
        cyc(); rd(CP0_CAUSE, "rst_cause", 32'h0);
        cyc(); rd(CP0_EPC, "rst_epc", 32'h0);
        expect_val("rst_hpc", SEL_HPC, 32'h0000_4180);
        cyc(); reset_n = 1'b1;
        rd(CP0_PRID, "prid", 32'h1926_0817);

        // 2. Enable IM[10]/IE, raise hw_int[0]; interrupt after two edges
        cyc();
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_SR; bus.cp0_wdata = 32'h0000_0401;
        hw_int = 6'b000001;
        expect_val("int_t0_take", SEL_TAKE, 32'h0);
        cyc(); bus.pc_m = 32'h1000;
        expect_val("int_t1_take", SEL_TAKE, 32'h0);
        cyc(); bus.pc_m = 32'h2000;
        expect_val("int_t2_take", SEL_TAKE, 32'h1);
        cyc(); rd(CP0_SR, "int_sr_exl", 32'h0000_0403);
        expect_val("int_masked", SEL_TAKE, 32'h0);
        cyc(); rd(CP0_CAUSE, "int_cause", 32'h0000_0400);
        cyc(); rd(CP0_EPC, "int_epc", 32'h0000_2000);
        hw_int = 6'b0;

        // 4. EXL=1 masks both exceptions and interrupts; ERET returns
        cyc(); bus.exc_code_m = EXC_ADEL;
        expect_val("exl_mask_exc", SEL_TAKE, 32'h0);
        cyc(); bus.exc_code_m = EXC_ADES;
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_EPC; bus.cp0_wdata = 32'h0000_3010;
        expect_val("exl_mask_ades", SEL_TAKE, 32'h0);
        cyc(); bus.is_eret = 1'b1;
        expect_val("eret_epc", SEL_EPC, 32'h0000_3010);
        expect_val("eret_take", SEL_TAKE, 32'h0);
        cyc(); rd(CP0_SR, "eret_sr", 32'h0000_0401);
        cyc(); rd(CP0_EPC, "mtc0_epc", 32'h0000_3010);

        // 3. Overflow in a delay slot
        cyc();
        bus.exc_code_m = EXC_OV; bus.pc_m = 32'h3008; bus.bd_m = 1'b1;
        expect_val("ov_take", SEL_TAKE, 32'h1);
        expect_val("ov_hpc", SEL_HPC, 32'h0000_4180);
        cyc(); rd(CP0_CAUSE, "ov_cause", 32'h8000_0030);
        cyc(); rd(CP0_EPC, "ov_epc", 32'h0000_3004);

        // 5. ERET with same-cycle MTC0 EPC bypass
        cyc();
        bus.is_eret = 1'b1;
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_EPC; bus.cp0_wdata = 32'h0000_3020;
        expect_val("bypass_epc", SEL_EPC, 32'h0000_3020);
        cyc(); rd(CP0_SR, "bypass_sr", 32'h0000_0401);
        cyc(); rd(CP0_EPC, "bypass_epcreg", 32'h0000_3020);
        //    MTC0 SR colliding with an Ov exception is dropped
        cyc();
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_SR; bus.cp0_wdata = 32'h0;
        bus.exc_code_m = EXC_OV; bus.pc_m = 32'h4000;
        expect_val("drop_take", SEL_TAKE, 32'h1);
        cyc(); rd(CP0_SR, "drop_sr", 32'h0000_0403);
        cyc(); rd(CP0_EPC, "drop_epc", 32'h0000_4000);

        // 6. Interrupt and RI in the same cycle: interrupt wins
        cyc();
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_SR; bus.cp0_wdata = 32'h0000_0401;
        hw_int = 6'b000001;
        cyc(); rd(CP0_SR, "pri_sr", 32'h0000_0401);
        expect_val("pri_t1_take", SEL_TAKE, 32'h0);
        cyc();
        bus.exc_code_m = EXC_RI; bus.pc_m = 32'h5000;
        expect_val("pri_take", SEL_TAKE, 32'h1);
        cyc(); hw_int = 6'b0;
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_CAUSE; bus.cp0_wdata = 32'hFFFF_FFFF;
        expect_val("pri_cause", SEL_RDATA, 32'h0000_0400);
        cyc(); rd(CP0_CAUSE, "cause_ro", 32'h0000_0400);
        cyc(); rd(CP0_EPC, "pri_epc", 32'h0000_5000);

        // Reset in the middle of the handler clears EXL at once
        cyc();
        #1;
        reset_n = 1'b0;
        rd(CP0_SR, "midrst_sr", 32'h0);
        cyc(); rd(CP0_CAUSE, "midrst_cause", 32'h0);
        cyc(); reset_n = 1'b1;

        // Let the monitor drain, bounded
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending checks, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
